// File: rtl/eth_rx_word_packer.sv
// Packs MAC receive bytes little-endian into 32-bit words behind a small FWFT FIFO with frame tagging.
// Optional frame_len / drop_cnt statistics are built only when ETH_RX_PACK_STATS_EN is defined.
module eth_rx_word_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      rx_axis_tdata,
    input  logic                            rx_axis_tvalid,
    input  logic                            rx_axis_tlast,
    input  logic                            rx_axis_tuser,
    output logic [31:0]                     m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            m_last,
    output logic [2:0]                      m_bytes,
    output logic                            m_err,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            frame_good,
    output logic                            frame_bad,
    output logic                            overflow,
    output logic [LEN_WIDTH-1:0]            frame_len,
    output logic [15:0]                     drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DATA_LIMIT = CW'(FIFO_DEPTH - 1);

    typedef enum logic {ST_ACC, ST_DROP} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [2:0]  bytes;
        logic        err;
    } entry_t;

    state_t          state_q, state_d;
    logic [1:0]      lane_q, lane_d;
    logic [23:0]     acc_q, acc_d;
    logic            started_q, started_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          mem_q [FIFO_DEPTH];
    entry_t          mem_d [FIFO_DEPTH];
    logic            good_q, good_d;
    logic            bad_q, bad_d;
    logic            ovf_q, ovf_d;

    logic            push;
    logic            pop;
    logic            room;
    logic            eof_ovf;
    logic [31:0]     word;
    entry_t          push_entry;

    // Consumer handshake: a word transfers on any clock edge where m_valid and m_ready
    // are both high; while m_valid=1 and m_ready=0 the head entry is held unchanged.
    assign pop  = (count_q != '0) && m_ready;
    // The limit uses the pre-pop count so the last slot stays free for a terminator.
    assign room = count_q < DATA_LIMIT;

    always_comb begin
        word = 32'h0;
        case (lane_q)
            2'd0:    word = {24'h0, rx_axis_tdata};
            2'd1:    word = {16'h0, rx_axis_tdata, acc_q[7:0]};
            2'd2:    word = {8'h0, rx_axis_tdata, acc_q[15:0]};
            default: word = {rx_axis_tdata, acc_q};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        acc_d      = acc_q;
        started_d  = started_q;
        push       = 1'b0;
        push_entry = '0;
        good_d     = 1'b0;
        bad_d      = 1'b0;
        ovf_d      = 1'b0;
        eof_ovf    = 1'b0;

        if (rx_axis_tvalid) begin
            if (state_q == ST_ACC) begin
                if (rx_axis_tlast || lane_q == 2'd3) begin
                    lane_d = 2'd0;
                    acc_d  = 24'h0;
                    if (room) begin
                        push       = 1'b1;
                        push_entry = '{data: word, last: rx_axis_tlast,
                                       bytes: {1'b0, lane_q} + 3'd1,
                                       err: rx_axis_tlast & rx_axis_tuser};
                        started_d  = !rx_axis_tlast;
                        good_d     = rx_axis_tlast & !rx_axis_tuser;
                        bad_d      = rx_axis_tlast & rx_axis_tuser;
                    end else begin
                        ovf_d = 1'b1;
                        if (rx_axis_tlast) begin
                            eof_ovf = 1'b1;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                end else begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0:    acc_d[7:0]   = rx_axis_tdata;
                        2'd1:    acc_d[15:8]  = rx_axis_tdata;
                        default: acc_d[23:16] = rx_axis_tdata;
                    endcase
                end
            end else if (rx_axis_tlast) begin
                eof_ovf = 1'b1;
            end
        end

        // A frame that already has words queued is closed with an error terminator.
        if (eof_ovf) begin
            if (started_q) begin
                push       = 1'b1;
                push_entry = '{data: 32'h0, last: 1'b1, bytes: 3'd0, err: 1'b1};
            end
            started_d = 1'b0;
            bad_d     = 1'b1;
            state_d   = ST_ACC;
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            lane_q    <= 2'd0;
            acc_q     <= 24'h0;
            started_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            good_q    <= 1'b0;
            bad_q     <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            acc_q     <= acc_d;
            started_q <= started_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            ovf_q     <= ovf_d;
            mem_q     <= mem_d;
        end
    end

    assign m_valid    = count_q != '0;
    assign m_data     = mem_q[rd_ptr_q].data;
    assign m_last     = mem_q[rd_ptr_q].last;
    assign m_bytes    = mem_q[rd_ptr_q].bytes;
    assign m_err      = mem_q[rd_ptr_q].err;
    assign fifo_count = count_q;
    assign frame_good = good_q;
    assign frame_bad  = bad_q;
    assign overflow   = ovf_q;

`ifdef ETH_RX_PACK_STATS_EN
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = {LEN_WIDTH{1'b1}};

    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] len_inc;
    logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
    logic [15:0]          drop_q, drop_d;

    // Discarded bytes still count toward the frame length.
    always_comb begin
        len_d       = len_q;
        frame_len_d = frame_len_q;
        drop_d      = drop_q;
        len_inc     = (len_q == LEN_MAX) ? len_q : len_q + LEN_WIDTH'(1);
        if (rx_axis_tvalid) begin
            if (rx_axis_tlast) begin
                frame_len_d = len_inc;
                len_d       = '0;
            end else begin
                len_d = len_inc;
            end
        end
        if (ovf_d && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            frame_len_q <= '0;
            drop_q      <= 16'h0;
        end else begin
            len_q       <= len_d;
            frame_len_q <= frame_len_d;
            drop_q      <= drop_d;
        end
    end

    assign frame_len = frame_len_q;
    assign drop_cnt  = drop_q;
`else
    assign frame_len = '0;
    assign drop_cnt  = 16'h0;
`endif

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Directed bench for eth_rx_word_packer: packing, status pulses, overflow/terminator handling, reset mid-frame.
module tb_eth_rx_word_packer;
    localparam int FIFO_DEPTH = 16;
    localparam int LEN_WIDTH  = 16;
`ifdef ETH_RX_PACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  rx_axis_tdata;
    logic        rx_axis_tvalid;
    logic        rx_axis_tlast;
    logic        rx_axis_tuser;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [2:0]  m_bytes;
    logic        m_err;
    logic [4:0]  fifo_count;
    logic        frame_good;
    logic        frame_bad;
    logic        overflow;
    logic [15:0] frame_len;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    eth_rx_word_packer #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .rx_axis_tdata(rx_axis_tdata), .rx_axis_tvalid(rx_axis_tvalid),
        .rx_axis_tlast(rx_axis_tlast), .rx_axis_tuser(rx_axis_tuser),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .m_bytes(m_bytes), .m_err(m_err),
        .fifo_count(fifo_count), .frame_good(frame_good), .frame_bad(frame_bad),
        .overflow(overflow), .frame_len(frame_len), .drop_cnt(drop_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers: every task returns 1 ns after the edge that consumed its stimulus.
    task automatic send_byte(input logic [7:0] b, input logic last, input logic user);
        rx_axis_tdata  = b;
        rx_axis_tvalid = 1'b1;
        rx_axis_tlast  = last;
        rx_axis_tuser  = user;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
        rx_axis_tuser  = 1'b0;
        rx_axis_tdata  = 8'h00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        n_checks++; if ({frame_good, frame_bad, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {frame_good, frame_bad, overflow}); end
        n_checks++; if (frame_len !== 16'h0 || drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stats: got len=%0d drop=%0d want 0 0", frame_len, drop_cnt); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic_frame();
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, 1'b0);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h04030201) begin n_fail++; $display("FAIL basic_word0: got v=%b %h want v=1 04030201", m_valid, m_data); end
        n_checks++; if (m_last !== 1'b0 || m_bytes !== 3'd4) begin n_fail++; $display("FAIL basic_word0_tag: got last=%b bytes=%0d want 0 4", m_last, m_bytes); end
        for (int i = 5; i <= 8; i++) send_byte(8'(i), i == 8, 1'b0);
        n_checks++; if (m_data !== 32'h08070605) begin n_fail++; $display("FAIL basic_word1: got %h want 08070605", m_data); end
        n_checks++; if ({m_last, m_bytes, m_err} !== {1'b1, 3'd4, 1'b0}) begin n_fail++; $display("FAIL basic_word1_tag: got last=%b bytes=%0d err=%b want 1 4 0", m_last, m_bytes, m_err); end
        n_checks++; if (frame_good !== 1'b1 || frame_bad !== 1'b0) begin n_fail++; $display("FAIL basic_status: got good=%b bad=%b want 1 0", frame_good, frame_bad); end
        n_checks++; if (frame_len !== (STATS ? 16'd8 : 16'd0)) begin n_fail++; $display("FAIL basic_len: got %0d want %0d", frame_len, STATS ? 8 : 0); end
        idle(1);
        n_checks++; if (frame_good !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL basic_after: got good=%b count=%0d want 0 0", frame_good, fifo_count); end
    endtask

    task automatic test_single_byte();
        m_ready = 1'b0;
        send_byte(8'hAA, 1'b1, 1'b0);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h000000AA) begin n_fail++; $display("FAIL single_word: got v=%b %h want v=1 000000aa", m_valid, m_data); end
        n_checks++; if ({m_last, m_bytes, m_err} !== {1'b1, 3'd1, 1'b0}) begin n_fail++; $display("FAIL single_tag: got last=%b bytes=%0d err=%b want 1 1 0", m_last, m_bytes, m_err); end
        n_checks++; if (frame_good !== 1'b1) begin n_fail++; $display("FAIL single_good: got %b want 1", frame_good); end
        idle(2);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h000000AA || m_bytes !== 3'd1) begin n_fail++; $display("FAIL single_hold: got v=%b %h bytes=%0d want 1 000000aa 1", m_valid, m_data, m_bytes); end
        n_checks++; if (frame_good !== 1'b0) begin n_fail++; $display("FAIL single_pulse_len: got %b want 0", frame_good); end
        m_ready = 1'b1;
        idle(1);
        n_checks++; if (m_valid !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL single_pop: got v=%b count=%0d want 0 0", m_valid, fifo_count); end
    endtask

    task automatic test_tuser_frame();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), i == 4, i == 4);
        n_checks++; if (fifo_count !== 5'd2) begin n_fail++; $display("FAIL tuser_count: got %0d want 2", fifo_count); end
        n_checks++; if (frame_bad !== 1'b1 || frame_good !== 1'b0) begin n_fail++; $display("FAIL tuser_status: got good=%b bad=%b want 0 1", frame_good, frame_bad); end
        n_checks++; if (m_data !== 32'h14131211 || m_last !== 1'b0) begin n_fail++; $display("FAIL tuser_word0: got %h last=%b want 14131211 0", m_data, m_last); end
        m_ready = 1'b1;
        idle(1);
        n_checks++; if (m_data !== 32'h00000015) begin n_fail++; $display("FAIL tuser_word1: got %h want 00000015", m_data); end
        n_checks++; if ({m_last, m_bytes, m_err} !== {1'b1, 3'd1, 1'b1}) begin n_fail++; $display("FAIL tuser_tag: got last=%b bytes=%0d err=%b want 1 1 1", m_last, m_bytes, m_err); end
        n_checks++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL tuser_pop_count: got %0d want 1", fifo_count); end
        idle(1);
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL tuser_empty: got %0d want 0", fifo_count); end
        m_ready = 1'b0;
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            send_byte(8'(i), i == 80, 1'b0);
            n_checks++; if (overflow !== (i == 64)) begin n_fail++; $display("FAIL ovf_pulse_byte%0d: got %b want %b", i, overflow, i == 64); end
            if (i == 60) begin
                n_checks++; if (fifo_count !== 5'd15) begin n_fail++; $display("FAIL ovf_count60: got %0d want 15", fifo_count); end
            end
        end
        n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count_end: got %0d want 16", fifo_count); end
        n_checks++; if (frame_bad !== 1'b1 || frame_good !== 1'b0) begin n_fail++; $display("FAIL ovf_status: got good=%b bad=%b want 0 1", frame_good, frame_bad); end
        n_checks++; if (drop_cnt !== (STATS ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL ovf_drop: got %0d want %0d", drop_cnt, STATS ? 1 : 0); end
        n_checks++; if (frame_len !== (STATS ? 16'd80 : 16'd0)) begin n_fail++; $display("FAIL ovf_len: got %0d want %0d", frame_len, STATS ? 80 : 0); end
    endtask

    task automatic test_full_drop();
        for (int i = 1; i <= 4; i++) send_byte(8'hC0 + 8'(i), i == 4, 1'b0);
        n_checks++; if (overflow !== 1'b1 || frame_bad !== 1'b1) begin n_fail++; $display("FAIL full_pulses: got ovf=%b bad=%b want 1 1", overflow, frame_bad); end
        n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", fifo_count); end
        n_checks++; if (drop_cnt !== (STATS ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL full_drop: got %0d want %0d", drop_cnt, STATS ? 2 : 0); end
        n_checks++; if (frame_len !== (STATS ? 16'd4 : 16'd0)) begin n_fail++; $display("FAIL full_len: got %0d want %0d", frame_len, STATS ? 4 : 0); end
        idle(1);
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [31:0] exp_data;
            logic [4:0]  exp_tag;
            if (k < 15) begin
                exp_data = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
                exp_tag  = {1'b1, 1'b0, 3'd4};
            end else begin
                exp_data = 32'h0;
                exp_tag  = {1'b1, 1'b1, 3'd0};
            end
            n_checks++; if (m_data !== exp_data || {m_valid, m_last, m_bytes} !== exp_tag) begin
                n_fail++; $display("FAIL drain_%0d: got %h v/last/bytes=%b want %h %b", k, m_data, {m_valid, m_last, m_bytes}, exp_data, exp_tag);
            end
            if (k == 15) begin
                n_checks++; if (m_err !== 1'b1) begin n_fail++; $display("FAIL drain_term_err: got %b want 1", m_err); end
            end
            idle(1);
        end
        n_checks++; if (m_valid !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL drain_empty: got v=%b count=%0d want 0 0", m_valid, fifo_count); end
    endtask

    task automatic test_reset_mid_frame();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'h21 + 8'(i), 1'b0, 1'b0);
        n_checks++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL midrst_pre: got %0d want 1", fifo_count); end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        n_checks++; if (fifo_count !== 5'd0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flush: got count=%0d v=%b want 0 0", fifo_count, m_valid); end
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), i == 3, 1'b0);
        n_checks++; if (m_data !== 32'h34333231 || {m_last, m_bytes} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL midrst_word: got %h last=%b bytes=%0d want 34333231 1 4", m_data, m_last, m_bytes); end
        n_checks++; if (frame_good !== 1'b1 || fifo_count !== 5'd1) begin n_fail++; $display("FAIL midrst_status: got good=%b count=%0d want 1 1", frame_good, fifo_count); end
        n_checks++; if (frame_len !== (STATS ? 16'd4 : 16'd0)) begin n_fail++; $display("FAIL midrst_len: got %0d want %0d", frame_len, STATS ? 4 : 0); end
        idle(1);
    endtask

    initial begin
        rst            = 1'b1;
        m_ready        = 1'b0;
        rx_axis_tdata  = 8'h00;
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
        rx_axis_tuser  = 1'b0;
        #1;
        test_reset();
        test_basic_frame();
        test_single_byte();
        test_tuser_frame();
        test_overflow();
        test_full_drop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
